// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and IDLE/RUN/HALT sequencing.
// Optional perf counters (fetch_cnt_o, bubble_cnt_o) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                   REGI_SIZE = 16,
  parameter int                   PC_BITS   = 10,
  parameter logic [REGI_SIZE-1:0] NOP_INSTR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stall_i,
  input  logic                 jump_en_i,
  input  logic [1:0]           cond_i,
  input  logic [PC_BITS-1:0]   jump_addr_i,
  input  logic [1:0]           alu_flags_i,
  input  logic                 end_i,
  output logic [PC_BITS-1:0]   imem_addr_o,
  input  logic [REGI_SIZE-1:0] imem_data_i,
  output logic [REGI_SIZE-1:0] instr_o,
  output logic [REGI_SIZE-1:0] next_pc_o,
  output logic                 valid_o,
  output logic                 halted_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          fetch_cnt_o,
  output logic [15:0]          bubble_cnt_o,
`endif
  output logic [1:0]           state_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  localparam logic [PC_BITS-1:0] PC_ONE = 1;

  logic [1:0]         state_q;
  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_inc;
  logic               cond_ok;
  logic               take;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    cond_ok = 1'b0;
    case (cond_i)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = alu_flags_i[0];
      2'b10:   cond_ok = ~alu_flags_i[0];
      default: cond_ok = alu_flags_i[1];
    endcase
  end

  assign take   = jump_en_i & cond_ok;
  assign pc_inc = pc_q + PC_ONE;  // wraps modulo 2**PC_BITS

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_o   <= NOP_INSTR;
      next_pc_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) state_q <= S_RUN;
        end
        S_RUN: begin
          if (end_i) begin
            state_q <= S_HALT;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
          end else if (take) begin
            pc_q    <= jump_addr_i;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
          end else if (!stall_i) begin
            instr_o   <= imem_data_i;
            next_pc_o <= REGI_SIZE'(pc_inc);
            valid_o   <= 1'b1;
            pc_q      <= pc_inc;
          end
        end
        S_HALT: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic run_fetch;
  logic run_bubble;

  assign run_fetch  = (state_q == S_RUN) & ~end_i & ~take & ~stall_i;
  assign run_bubble = (state_q == S_RUN) & ~end_i & (take | stall_i);

  // Counters saturate rather than wrap so long runs never report a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (run_fetch && fetch_cnt_o != '1)   fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (run_bubble && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`endif

  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == S_HALT);
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven vectors fed through an expectation queue,
// plus hand sequences for asynchronous reset. Define FETCH_PERF_CNT_EN to also check counters.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stall_i, jump_en_i, end_i;
  logic [1:0]  cond_i, alu_flags_i;
  logic [9:0]  jump_addr_i;
  logic [9:0]  imem_addr_o;
  logic [15:0] imem_data_i;
  logic [15:0] instr_o, next_pc_o;
  logic        valid_o, halted_o;
  logic [1:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [15:0] bubble_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .jump_en_i   (jump_en_i),
    .cond_i      (cond_i),
    .jump_addr_i (jump_addr_i),
    .alu_flags_i (alu_flags_i),
    .end_i       (end_i),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .instr_o     (instr_o),
    .next_pc_o   (next_pc_o),
    .valid_o     (valid_o),
    .halted_o    (halted_o),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o (fetch_cnt_o),
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // ROM contents: ROM[i] = 0x1000 + i
  assign imem_data_i = 16'h1000 + {6'b0, imem_addr_o};

  typedef struct {
    logic        start, stall, jen;
    logic [1:0]  cond;
    logic [9:0]  jaddr;
    logic [1:0]  flags;
    logic        fin;
    logic [15:0] e_instr;
    logic [15:0] e_np;
    logic        chk_np;
    logic        e_valid;
    logic [9:0]  e_pc;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[25];
  vec_t sb[$];

  function automatic vec_t mk(input logic start, stall, jen, input logic [1:0] cond,
                              input logic [9:0] jaddr, input logic [1:0] flags, input logic fin,
                              input logic [15:0] e_instr, e_np, input logic chk_np, e_valid,
                              input logic [9:0] e_pc, input logic [1:0] e_state);
    vec_t v;
    v.start = start; v.stall = stall; v.jen = jen; v.cond = cond; v.jaddr = jaddr;
    v.flags = flags; v.fin = fin; v.e_instr = e_instr; v.e_np = e_np; v.chk_np = chk_np;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_state = e_state;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".instr"},  32'(instr_o),     32'(NOP));
    check({tag, ".np"},     32'(next_pc_o),   32'h0);
    check({tag, ".valid"},  32'(valid_o),     32'h0);
    check({tag, ".halted"}, 32'(halted_o),    32'h0);
    check({tag, ".state"},  32'(state_o),     32'h0);
    check({tag, ".pc"},     32'(imem_addr_o), 32'h0);
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; stall_i = 1'b0; jump_en_i = 1'b0; end_i = 1'b0;
    cond_i = 2'b00; alu_flags_i = 2'b00; jump_addr_i = 10'h0;
  endtask

  initial begin
    // start stall jen cond jaddr flags fin | instr np chk_np valid pc state
    vecs[0]  = mk(0,1,1,2'b00,10'h055,2'b00,1, NOP,     16'h0,  0,0,10'h000,2'b00);
    vecs[1]  = mk(1,0,0,2'b00,10'h000,2'b00,0, NOP,     16'h0,  1,0,10'h000,2'b01);
    vecs[2]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1000,16'h1,  1,1,10'h001,2'b01);
    vecs[3]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1001,16'h2,  1,1,10'h002,2'b01);
    vecs[4]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1002,16'h3,  1,1,10'h003,2'b01);
    vecs[5]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1003,16'h4,  1,1,10'h004,2'b01);
    vecs[6]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1004,16'h5,  1,1,10'h005,2'b01);
    vecs[7]  = mk(0,0,1,2'b01,10'h3F0,2'b01,0, NOP,     16'h0,  0,0,10'h3F0,2'b01);
    vecs[8]  = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h13F0,16'h3F1,1,1,10'h3F1,2'b01);
    vecs[9]  = mk(0,0,1,2'b01,10'h006,2'b00,0, 16'h13F1,16'h3F2,1,1,10'h3F2,2'b01);
    vecs[10] = mk(0,0,1,2'b10,10'h010,2'b01,0, 16'h13F2,16'h3F3,1,1,10'h3F3,2'b01);
    vecs[11] = mk(0,0,1,2'b11,10'h005,2'b10,0, NOP,     16'h0,  0,0,10'h005,2'b01);
    vecs[12] = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1005,16'h6,  1,1,10'h006,2'b01);
    vecs[13] = mk(0,0,1,2'b11,10'h200,2'b01,0, 16'h1006,16'h7,  1,1,10'h007,2'b01);
    vecs[14] = mk(0,1,0,2'b00,10'h000,2'b00,0, 16'h1006,16'h7,  1,1,10'h007,2'b01);
    vecs[15] = mk(0,1,0,2'b00,10'h000,2'b00,0, 16'h1006,16'h7,  1,1,10'h007,2'b01);
    vecs[16] = mk(0,1,0,2'b00,10'h000,2'b00,0, 16'h1006,16'h7,  1,1,10'h007,2'b01);
    vecs[17] = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1007,16'h8,  1,1,10'h008,2'b01);
    vecs[18] = mk(0,1,0,2'b00,10'h000,2'b00,0, 16'h1007,16'h8,  1,1,10'h008,2'b01);
    vecs[19] = mk(0,1,1,2'b00,10'h3FF,2'b00,0, NOP,     16'h0,  0,0,10'h3FF,2'b01);
    vecs[20] = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h13FF,16'h0,  1,1,10'h000,2'b01);
    vecs[21] = mk(0,0,0,2'b00,10'h000,2'b00,0, 16'h1000,16'h1,  1,1,10'h001,2'b01);
    vecs[22] = mk(0,1,1,2'b00,10'h100,2'b00,1, NOP,     16'h0,  0,0,10'h001,2'b10);
    vecs[23] = mk(1,0,0,2'b00,10'h000,2'b00,0, NOP,     16'h0,  0,0,10'h001,2'b10);
    vecs[24] = mk(0,0,0,2'b00,10'h000,2'b00,0, NOP,     16'h0,  0,0,10'h001,2'b10);

    idle_inputs();
    rst = 1'b1;
    #12 rst = 1'b0;
    #1 check_reset_values("reset");
`ifdef FETCH_PERF_CNT_EN
    check("reset.fetch_cnt",  fetch_cnt_o,         32'd0);
    check("reset.bubble_cnt", 32'(bubble_cnt_o),   32'd0);
`endif

    for (int i = 0; i < 25; i++) begin
      vec_t e;
      start_i = vecs[i].start; stall_i = vecs[i].stall; jump_en_i = vecs[i].jen;
      cond_i = vecs[i].cond; jump_addr_i = vecs[i].jaddr; alu_flags_i = vecs[i].flags;
      end_i = vecs[i].fin;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d.instr", i),  32'(instr_o),     32'(e.e_instr));
      check($sformatf("v%0d.valid", i),  32'(valid_o),     32'(e.e_valid));
      check($sformatf("v%0d.pc", i),     32'(imem_addr_o), 32'(e.e_pc));
      check($sformatf("v%0d.state", i),  32'(state_o),     32'(e.e_state));
      check($sformatf("v%0d.halted", i), 32'(halted_o),    32'(e.e_state == 2'b10));
      if (e.chk_np) check($sformatf("v%0d.np", i), 32'(next_pc_o), 32'(e.e_np));
    end
    idle_inputs();

`ifdef FETCH_PERF_CNT_EN
    check("run.fetch_cnt",  fetch_cnt_o,       32'd13);
    check("run.bubble_cnt", 32'(bubble_cnt_o), 32'd7);
`endif

    // Asynchronous reset while halted, well before the next edge.
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst_halt");
`ifdef FETCH_PERF_CNT_EN
    check("async_rst.fetch_cnt",  fetch_cnt_o,       32'd0);
    check("async_rst.bubble_cnt", 32'(bubble_cnt_o), 32'd0);
`endif
    #3 rst = 1'b0;

    // Restart, fetch two instructions, then reset mid-cycle during RUN.
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("restart.state", 32'(state_o), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("restart.instr", 32'(instr_o),     32'h1001);
    check("restart.np",    32'(next_pc_o),   32'h2);
    check("restart.valid", 32'(valid_o),     32'h1);
    check("restart.pc",    32'(imem_addr_o), 32'h2);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst_run");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("after_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
